// File: rtl/cla_serial_add_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
package cla_serial_add_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_serial_add_cla4.sv
// Combinational 4-bit carry-lookahead slice (module cla4), reused one nibble per clock.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries expanded in two-level form rather than rippled.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule

// File: rtl/cla_serial_add.sv
// Multi-cycle WIDTH-bit adder: one cla4 slice, one nibble per clock, registered carry.
// Optional signed-overflow output enabled by defining CLA_SERIAL_OVF_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | in_ready high, waiting for operands
// ST_RUN  | adding nibble idx, carry rippled through carry_q
// ST_DONE | out_valid high, result held until out_ready
module cla_serial_add
    import cla_serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef CLA_SERIAL_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int N  = WIDTH / NIB;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_bad_width
            $fatal(1, "cla_serial_add: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry_q;
    logic             co_q;
    logic [IW-1:0]    idx_q;
    logic [3:0]       a_nib, b_nib, sum_nib;
    logic             nib_co;
    logic             last_nib;

    // Shift-based nibble select keeps the mux legal for every idx encoding.
    assign a_sh     = a_q >> (NIB * idx_q);
    assign b_sh     = b_q >> (NIB * idx_q);
    assign a_nib    = a_sh[3:0];
    assign b_nib    = b_sh[3:0];
    assign last_nib = (idx_q == IW'(N - 1));

    cla4 u_cla4 (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (sum_nib),
        .co (nib_co)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_nib)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign co        = co_q;

`ifdef CLA_SERIAL_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
`ifdef CLA_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ci;
                        idx_q   <= '0;
                        s_q     <= '0;
                    end
                end
                ST_RUN: begin
                    // s was cleared on accept, so OR-ing the nibble into place is exact.
                    s_q     <= s_q | (WIDTH'(sum_nib) << (NIB * idx_q));
                    carry_q <= nib_co;
                    if (last_nib) begin
                        co_q  <= nib_co;
`ifdef CLA_SERIAL_OVF_EN
                        ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nib[3] != a_q[WIDTH-1]);
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_add.sv
// Directed and random checks of cla_serial_add at WIDTH 16, 4 and 32.
module tb_cla_serial_add;

    logic        clk;
    logic        rst;
    logic [31:0] a_d, b_d;
    logic        ci_d;
    logic [2:0]  iv, ordy;

    logic        rdy16, vld16, co16;
    logic [15:0] s16;
    logic        rdy4, vld4, co4;
    logic [3:0]  s4;
    logic        rdy32, vld32, co32;
    logic [31:0] s32;
`ifdef CLA_SERIAL_OVF_EN
    logic        ovf16, ovf4, ovf32;
`endif

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cla_serial_add #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy16),
        .a(a_d[15:0]), .b(b_d[15:0]), .ci(ci_d),
        .out_valid(vld16), .out_ready(ordy[0]), .s(s16), .co(co16)
`ifdef CLA_SERIAL_OVF_EN
       ,.ovf(ovf16)
`endif
    );

    cla_serial_add #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy4),
        .a(a_d[3:0]), .b(b_d[3:0]), .ci(ci_d),
        .out_valid(vld4), .out_ready(ordy[1]), .s(s4), .co(co4)
`ifdef CLA_SERIAL_OVF_EN
       ,.ovf(ovf4)
`endif
    );

    cla_serial_add #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy32),
        .a(a_d), .b(b_d), .ci(ci_d),
        .out_valid(vld32), .out_ready(ordy[2]), .s(s32), .co(co32)
`ifdef CLA_SERIAL_OVF_EN
       ,.ovf(ovf32)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int k);
        case (k)
            0:       return rdy16;
            1:       return rdy4;
            default: return rdy32;
        endcase
    endfunction

    function automatic logic vld(input int k);
        case (k)
            0:       return vld16;
            1:       return vld4;
            default: return vld32;
        endcase
    endfunction

    function automatic logic [32:0] res(input int k);
        case (k)
            0:       return {16'b0, co16, s16};
            1:       return {28'b0, co4, s4};
            default: return {co32, s32};
        endcase
    endfunction

    // Present operands and return at the negedge just after the accept edge.
    task automatic send(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic civ, input bit keep_valid);
        int n = 0;
        @(negedge clk);
        a_d = av; b_d = bv; ci_d = civ; iv[k] = 1'b1;
        while (!rdy(k) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_wait", 64'(n < 50), 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) iv[k] = 1'b0;
    endtask

    // lat counts negedges from the accept edge until out_valid is seen.
    task automatic wait_valid(input int k, output int lat);
        lat = 1;
        while (!vld(k) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_val("valid_wait", 64'(lat < 100), 64'd1);
    endtask

    task automatic take(input int k);
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] av, bv;
        logic        civ;
        logic [32:0] held;

        rst = 1'b1; iv = '0; ordy = '0; a_d = '0; b_d = '0; ci_d = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_in_ready", 64'(rdy16), 64'd1);
        check_val("rst_out_valid", 64'(vld16), 64'd0);
        check_val("rst_result", 64'(res(0)), 64'd0);
        check_val("rst_in_ready32", 64'(rdy32), 64'd1);
`ifdef CLA_SERIAL_OVF_EN
        check_val("rst_ovf", 64'(ovf16), 64'd0);
`endif

        // Carry through every nibble
        send(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
        wait_valid(0, lat);
        check_val("t1_latency", 64'(lat), 64'd5);
        check_val("t1_result", 64'(res(0)), 64'h1_0000);
        take(0);

        // Result held while consumer stalls
        send(0, 32'h1234, 32'h4321, 1'b1, 1'b0);
        wait_valid(0, lat);
        check_val("t2_result", 64'(res(0)), 64'h0_5556);
        held = res(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t2_hold_valid", 64'(vld16), 64'd1);
            check_val("t2_hold_result", 64'(res(0)), 64'(held));
            check_val("t2_hold_in_ready", 64'(rdy16), 64'd0);
        end
        take(0);
        check_val("t2_after_take", 64'(vld16), 64'd0);

        // Reset in the second RUN cycle
        send(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t3_in_ready", 64'(rdy16), 64'd1);
        check_val("t3_out_valid", 64'(vld16), 64'd0);
        check_val("t3_s", 64'(s16), 64'd0);
        send(0, 32'h1, 32'h2, 1'b0, 1'b0);
        wait_valid(0, lat);
        check_val("t3_result", 64'(res(0)), 64'h0_0003);
        take(0);

        // in_valid held through RUN/DONE with a changing underneath
        send(0, 32'h0100, 32'h0010, 1'b0, 1'b1);
        lat = 1;
        while (!vld16 && lat < 100) begin
            a_d = $urandom;
            @(negedge clk);
            lat++;
        end
        check_val("t4_latency", 64'(lat), 64'd5);
        check_val("t4_result", 64'(res(0)), 64'h0_0110);
        check_val("t4_done_in_ready", 64'(rdy16), 64'd0);
        a_d = 32'h2000; b_d = 32'h0003; ci_d = 1'b0;
        take(0);
        check_val("t4_idle_in_ready", 64'(rdy16), 64'd1);
        @(negedge clk);
        check_val("t4_second_accept", 64'(rdy16), 64'd0);
        iv[0] = 1'b0;
        wait_valid(0, lat);
        check_val("t4_second_result", 64'(res(0)), 64'h0_2003);
        take(0);

`ifdef CLA_SERIAL_OVF_EN
        send(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
        wait_valid(0, lat);
        check_val("t5a_result", 64'(res(0)), 64'h0_8000);
        check_val("t5a_ovf", 64'(ovf16), 64'd1);
        take(0);
        send(0, 32'h8000, 32'hFFFF, 1'b0, 1'b0);
        wait_valid(0, lat);
        check_val("t5b_result", 64'(res(0)), 64'h1_7FFF);
        check_val("t5b_ovf", 64'(ovf16), 64'd1);
        take(0);
        send(0, 32'h0005, 32'hFFFB, 1'b0, 1'b0);
        wait_valid(0, lat);
        check_val("t5c_result", 64'(res(0)), 64'h1_0000);
        check_val("t5c_ovf", 64'(ovf16), 64'd0);
        take(0);
`endif

        // Random sweep: k=0 WIDTH16 (N=4), k=1 WIDTH4 (N=1), k=2 WIDTH32 (N=8)
        for (int k = 0; k < 3; k++) begin
            int w;
            int iters;
            w     = (k == 0) ? 16 : (k == 1) ? 4 : 32;
            iters = (k == 0) ? 200 : 1000;
            for (int i = 0; i < iters; i++) begin
                av  = $urandom;
                bv  = $urandom;
                civ = 1'($urandom_range(0, 1));
                if (w < 32) begin
                    av = av & ((32'd1 << w) - 32'd1);
                    bv = bv & ((32'd1 << w) - 32'd1);
                end
                send(k, av, bv, civ, 1'b0);
                wait_valid(k, lat);
                check_val($sformatf("rand_w%0d_latency", w), 64'(lat), 64'(w / 4 + 1));
                check_val($sformatf("rand_w%0d_sum", w), 64'(res(k)),
                          64'(33'(av) + 33'(bv) + 33'(civ)));
                take(k);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
